// File: rtl/kvs_pkg.sv
// Shared KVS definitions: default key/flag widths, the {flag, key} request
// record and the flag codes exchanged between eth_top and db_top.
package kvs_pkg;

  localparam int unsigned DEF_KEY_SIZE  = 96;
  localparam int unsigned DEF_FLAG_SIZE = 4;

  typedef enum logic [DEF_FLAG_SIZE-1:0] {
    KVS_FLAG_NONE = 4'h0,
    KVS_FLAG_GET  = 4'h1,
    KVS_FLAG_SET  = 4'h2,
    KVS_FLAG_DEL  = 4'h4,
    KVS_FLAG_HIT  = 4'h8
  } kvs_flag_e;

  typedef struct packed {
    logic [DEF_FLAG_SIZE-1:0] flag;
    logic [DEF_KEY_SIZE-1:0]  key;
  } kvs_req_t;

  function automatic int unsigned kvs_req_width(int unsigned key_size, int unsigned flag_size);
    return key_size + flag_size;
  endfunction

endpackage

// File: rtl/kvs_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is
// accepted when a read happens in the same cycle.
module kvs_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_ok) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kvs_port_mux.sv
// Round-robin mux of NUM_PORTS KVS request streams onto one db_top port, with
// in-order response steering. Define KVS_MUX_STATS_EN to build drop/spurious stats.
module kvs_port_mux
  import kvs_pkg::*;
#(
  parameter int unsigned KEY_SIZE     = DEF_KEY_SIZE,
  parameter int unsigned FLAG_SIZE    = DEF_FLAG_SIZE,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS*KEY_SIZE-1:0] in_key,
  input  logic [NUM_PORTS*FLAG_SIZE-1:0] in_flag,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*FLAG_SIZE-1:0] out_flag,
  output logic [KEY_SIZE-1:0]           db_in_key,
  output logic [FLAG_SIZE-1:0]          db_in_flag,
  output logic                          db_in_valid,
  input  logic                          db_out_valid,
  input  logic [FLAG_SIZE-1:0]          db_out_flag,
  output logic [NUM_PORTS*16-1:0]       drop_cnt,
  output logic                          err_spurious
);

  localparam int unsigned REQ_W = kvs_req_width(KEY_SIZE, FLAG_SIZE);
  localparam int unsigned PW    = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] req_full;
  logic [NUM_PORTS-1:0] req_empty;
  logic [NUM_PORTS-1:0] req_wr;
  logic [NUM_PORTS-1:0] req_pop;
  logic [REQ_W-1:0]     req_dout [NUM_PORTS];
  logic [REQ_W-1:0]     grant_req;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        tag_dout;
  logic                 grant_vld;
  logic                 issue;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 tag_pop;

  // A full FIFO still takes a write in the cycle it is popped.
  assign req_wr = in_valid & (~req_full | req_pop);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
    kvs_sync_fifo #(
      .WIDTH(REQ_W),
      .DEPTH(FIFO_DEPTH)
    ) u_req_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .wr_en(req_wr[p]),
      .din  ({in_flag[p*FLAG_SIZE +: FLAG_SIZE], in_key[p*KEY_SIZE +: KEY_SIZE]}),
      .rd_en(req_pop[p]),
      .dout (req_dout[p]),
      .full (req_full[p]),
      .empty(req_empty[p])
    );
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((32'(rr_ptr) + i) % NUM_PORTS);
      if (!grant_vld && !req_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // A response pop frees a tag slot for an issue in the same cycle.
  assign tag_pop   = db_out_valid && !tag_empty;
  assign issue     = grant_vld && (!tag_full || tag_pop);
  assign grant_req = req_dout[grant_idx];

  always_comb begin
    req_pop = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      req_pop[p] = issue && (grant_idx == PW'(p));
    end
  end

  kvs_sync_fifo #(
    .WIDTH(PW),
    .DEPTH(MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .wr_en(issue),
    .din  (grant_idx),
    .rd_en(tag_pop),
    .dout (tag_dout),
    .full (tag_full),
    .empty(tag_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      db_in_valid <= 1'b0;
      db_in_key   <= '0;
      db_in_flag  <= '0;
      out_valid   <= '0;
      out_flag    <= '0;
    end else begin
      db_in_valid <= issue;
      out_valid   <= '0;
      if (issue) begin
        db_in_key  <= grant_req[KEY_SIZE-1:0];
        db_in_flag <= grant_req[REQ_W-1:KEY_SIZE];
        rr_ptr     <= (32'(grant_idx) == NUM_PORTS - 1) ? '0 : PW'(32'(grant_idx) + 1);
      end
      if (tag_pop) begin
        out_valid[tag_dout]                           <= 1'b1;
        out_flag[32'(tag_dout)*FLAG_SIZE +: FLAG_SIZE] <= db_out_flag;
      end
    end
  end

`ifdef KVS_MUX_STATS_EN
  logic [NUM_PORTS*16-1:0] drop_q;
  logic                    spur_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
      spur_q <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (in_valid[p] && !req_wr[p] && drop_q[p*16 +: 16] != 16'hFFFF)
          drop_q[p*16 +: 16] <= drop_q[p*16 +: 16] + 16'd1;
      end
      if (db_out_valid && tag_empty) spur_q <= 1'b1;
    end
  end

  assign drop_cnt     = drop_q;
  assign err_spurious = spur_q;
`else
  assign drop_cnt     = '0;
  assign err_spurious = 1'b0;
`endif

endmodule

// File: tb/tb_kvs_port_mux.sv
// Scoreboard bench for kvs_port_mux (2 ports, depth 8, 16 in flight); stats
// expectations follow KVS_MUX_STATS_EN.
module tb_kvs_port_mux;

  localparam int unsigned KS = 96;
  localparam int unsigned FS = 4;
  localparam int unsigned NP = 2;
`ifdef KVS_MUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [KS-1:0] key;
    logic [FS-1:0] flag;
  } iss_t;

  typedef struct {
    int unsigned   port;
    logic [FS-1:0] flag;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*KS-1:0]  in_key = '0;
  logic [NP*FS-1:0]  in_flag = '0;
  logic [NP-1:0]     in_valid = '0;
  logic [NP-1:0]     out_valid;
  logic [NP*FS-1:0]  out_flag;
  logic [KS-1:0]     db_in_key;
  logic [FS-1:0]     db_in_flag;
  logic              db_in_valid;
  logic              db_out_valid = 1'b0;
  logic [FS-1:0]     db_out_flag = '0;
  logic [NP*16-1:0]  drop_cnt;
  logic              err_spurious;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  kvs_port_mux #(
    .KEY_SIZE(KS),
    .FLAG_SIZE(FS),
    .NUM_PORTS(NP),
    .FIFO_DEPTH(8),
    .MAX_INFLIGHT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_key(in_key),
    .in_flag(in_flag),
    .in_valid(in_valid),
    .out_valid(out_valid),
    .out_flag(out_flag),
    .db_in_key(db_in_key),
    .db_in_flag(db_in_flag),
    .db_in_valid(db_in_valid),
    .db_out_valid(db_out_valid),
    .db_out_flag(db_out_flag),
    .drop_cnt(drop_cnt),
    .err_spurious(err_spurious)
  );

  function automatic logic [KS-1:0] mk_key(int unsigned p, int unsigned i);
    return {32'hC0DE_0000 + 32'(p), 32'(i), 32'h5A5A_1234};
  endfunction

  task automatic do_reset();
    in_valid     = '0;
    db_out_valid = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_iss.delete();
    exp_rsp.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({db_in_valid, db_in_key, db_in_flag} !== '0) begin
      n_bad++; $display("FAIL reset_db: got valid=%b key=%h flag=%h, expected all 0", db_in_valid, db_in_key, db_in_flag);
    end
    n_cmp++;
    if ({out_valid, out_flag} !== '0) begin
      n_bad++; $display("FAIL reset_out: got out_valid=%b out_flag=%h, expected 0", out_valid, out_flag);
    end
    n_cmp++;
    if ({drop_cnt, err_spurious} !== '0) begin
      n_bad++; $display("FAIL reset_stats: got drop_cnt=%h err=%b, expected 0", drop_cnt, err_spurious);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    iss_t e;
    rsp_t r;
    logic [NP-1:0] eov;
    logic [KS-1:0] k;
    int unsigned lat;
    k   = 96'h0123_4567_89AB_CDEF_0123_45AB;
    lat = 0;
    in_valid = 2'b10;
    in_key[KS +: KS] = k;
    in_flag[FS +: FS] = 4'h1;
    exp_iss.push_back('{k, 4'h1});
    @(posedge clk); #1;
    in_valid = '0;
    for (int unsigned c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (db_in_valid === 1'b1) begin
        lat = c;
        n_cmp++;
        e = exp_iss.pop_front();
        if (db_in_key !== e.key || db_in_flag !== e.flag) begin
          n_bad++; $display("FAIL single_issue: got key=%h flag=%h expected key=%h flag=%h", db_in_key, db_in_flag, e.key, e.flag);
        end
      end
    end
    n_cmp++;
    if (lat != 2) begin
      n_bad++; $display("FAIL single_latency: got %0d cycles, expected 2", lat);
    end
    @(posedge clk); #1;
    db_out_valid = 1'b1;
    db_out_flag  = 4'h8;
    exp_rsp.push_back('{1, 4'h8});
    @(posedge clk); #1;
    db_out_valid = 1'b0;
    @(negedge clk);
    r = exp_rsp.pop_front();
    eov = '0;
    eov[r.port] = 1'b1;
    n_cmp++;
    if (out_valid !== eov || out_flag[r.port*FS +: FS] !== r.flag) begin
      n_bad++; $display("FAIL single_rsp: got out_valid=%b out_flag=%h expected %b flag %h", out_valid, out_flag, eov, r.flag);
    end
    n_cmp++;
    if (db_in_valid !== 1'b0 || db_in_key !== k || db_in_flag !== 4'h1) begin
      n_bad++; $display("FAIL single_db_hold: got valid=%b key=%h flag=%h expected 0/%h/1", db_in_valid, db_in_key, db_in_flag, k);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 2'b00 || out_flag[FS +: FS] !== 4'h8) begin
      n_bad++; $display("FAIL single_out_hold: got out_valid=%b out_flag=%h expected 00 with port1 flag 8", out_valid, out_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    iss_t e;
    rsp_t r;
    logic [NP-1:0] eov;
    do_reset();
    for (int unsigned i = 0; i < 8; i++)
      for (int unsigned p = 0; p < NP; p++) exp_iss.push_back('{mk_key(p, i), 4'(i + p)});
    for (int unsigned c = 0; c < 24; c++) begin
      in_valid = (c < 8) ? 2'b11 : 2'b00;
      for (int unsigned p = 0; p < NP; p++) begin
        in_key[p*KS +: KS]  = mk_key(p, c);
        in_flag[p*FS +: FS] = 4'(c + p);
      end
      @(negedge clk);
      if (db_in_valid === 1'b1) begin
        n_cmp++;
        if (exp_iss.size() == 0) begin
          n_bad++; $display("FAIL fair_issue: unexpected issue key=%h, expected none", db_in_key);
        end else begin
          e = exp_iss.pop_front();
          if (db_in_key !== e.key || db_in_flag !== e.flag) begin
            n_bad++; $display("FAIL fair_issue: got key=%h flag=%h expected key=%h flag=%h", db_in_key, db_in_flag, e.key, e.flag);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_iss.size() != 0) begin
      n_bad++; $display("FAIL fair_issue_count: %0d issues missing, expected 0", exp_iss.size());
    end
    for (int unsigned c = 0; c < 20; c++) begin
      db_out_valid = (c < 16);
      db_out_flag  = 4'(15 - c);
      if (c < 16) exp_rsp.push_back('{c % NP, 4'(15 - c)});
      @(negedge clk);
      if (out_valid !== '0) begin
        n_cmp++;
        if (exp_rsp.size() == 0) begin
          n_bad++; $display("FAIL fair_rsp: unexpected out_valid=%b, expected none", out_valid);
        end else begin
          r = exp_rsp.pop_front();
          eov = '0;
          eov[r.port] = 1'b1;
          if (out_valid !== eov || out_flag[r.port*FS +: FS] !== r.flag) begin
            n_bad++; $display("FAIL fair_rsp: got out_valid=%b out_flag=%h expected %b flag %h", out_valid, out_flag, eov, r.flag);
          end
        end
      end
      @(posedge clk); #1;
    end
    db_out_valid = 1'b0;
    n_cmp++;
    if (exp_rsp.size() != 0) begin
      n_bad++; $display("FAIL fair_rsp_count: %0d responses missing, expected 0", exp_rsp.size());
    end
  endtask

  // Leaves 16 tags outstanding and port 0 full, for test_reset_mid.
  task automatic test_overflow();
    iss_t e;
    rsp_t r;
    logic [NP-1:0] eov;
    do_reset();
    for (int unsigned i = 0; i < 16; i++) exp_iss.push_back('{mk_key(1, 100 + i), 4'h2});
    for (int unsigned c = 0; c < 47; c++) begin
      in_valid = (c < 16) ? 2'b10 : (c >= 24 && c < 34) ? 2'b01 : 2'b00;
      in_key[KS +: KS]  = mk_key(1, 100 + c);
      in_flag[FS +: FS] = 4'h2;
      in_key[0 +: KS]   = mk_key(0, 200 + c - 24);
      in_flag[0 +: FS]  = 4'h1;
      if (c == 38) begin
        // response frees one tag while port 0 is written and popped at once
        db_out_valid = 1'b1;
        db_out_flag  = 4'h3;
        in_valid     = 2'b01;
        in_key[0 +: KS] = mk_key(0, 300);
        exp_rsp.push_back('{1, 4'h3});
        exp_iss.push_back('{mk_key(0, 200), 4'h1});
      end else begin
        db_out_valid = 1'b0;
      end
      @(negedge clk);
      if (db_in_valid === 1'b1) begin
        n_cmp++;
        if (exp_iss.size() == 0) begin
          n_bad++; $display("FAIL ovf_issue: unexpected issue key=%h, expected none", db_in_key);
        end else begin
          e = exp_iss.pop_front();
          if (db_in_key !== e.key || db_in_flag !== e.flag) begin
            n_bad++; $display("FAIL ovf_issue: got key=%h flag=%h expected key=%h flag=%h", db_in_key, db_in_flag, e.key, e.flag);
          end
        end
      end
      if (out_valid !== '0) begin
        n_cmp++;
        if (exp_rsp.size() == 0) begin
          n_bad++; $display("FAIL ovf_rsp: unexpected out_valid=%b, expected none", out_valid);
        end else begin
          r = exp_rsp.pop_front();
          eov = '0;
          eov[r.port] = 1'b1;
          if (out_valid !== eov || out_flag[r.port*FS +: FS] !== r.flag) begin
            n_bad++; $display("FAIL ovf_rsp: got out_valid=%b out_flag=%h expected %b flag %h", out_valid, out_flag, eov, r.flag);
          end
        end
      end
      if (c == 37) begin
        n_cmp++;
        if (drop_cnt[15:0] !== (STATS ? 16'd2 : 16'd0)) begin
          n_bad++; $display("FAIL ovf_drops: got drop_cnt[0]=%0d expected %0d", drop_cnt[15:0], STATS ? 2 : 0);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_iss.size() != 0 || exp_rsp.size() != 0) begin
      n_bad++; $display("FAIL ovf_pending: %0d issues %0d responses missing, expected 0", exp_iss.size(), exp_rsp.size());
    end
    n_cmp++;
    if (drop_cnt !== (STATS ? 32'h0000_0002 : 32'h0)) begin
      n_bad++; $display("FAIL ovf_wr_on_pop: got drop_cnt=%h expected %h", drop_cnt, STATS ? 32'h2 : 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned pulses;
    pulses = 0;
    rst_n    = 1'b0;
    in_valid = 2'b11;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = '0;
    exp_iss.delete();
    exp_rsp.delete();
    @(negedge clk);
    n_cmp++;
    if ({db_in_valid, db_in_key, db_in_flag, out_valid, out_flag} !== '0) begin
      n_bad++; $display("FAIL mid_reset_out: got db_valid=%b key=%h flag=%h out_valid=%b out_flag=%h expected 0", db_in_valid, db_in_key, db_in_flag, out_valid, out_flag);
    end
    n_cmp++;
    if ({drop_cnt, err_spurious} !== '0) begin
      n_bad++; $display("FAIL mid_reset_stats: got drop_cnt=%h err=%b expected 0", drop_cnt, err_spurious);
    end
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk);
      if (db_in_valid !== 1'b0 || out_valid !== '0) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++; $display("FAIL mid_reset_quiet: got %0d cycles with activity, expected 0", pulses);
    end
    @(posedge clk); #1;
    db_out_valid = 1'b1;
    db_out_flag  = 4'h8;
    @(posedge clk); #1;
    db_out_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_spurious !== STATS || out_valid !== '0) begin
      n_bad++; $display("FAIL mid_stale_rsp: got err=%b out_valid=%b expected err=%b out_valid=00", err_spurious, out_valid, STATS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious();
    int unsigned pulses;
    pulses = 0;
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (err_spurious !== 1'b0) begin
      n_bad++; $display("FAIL spur_init: got err=%b expected 0", err_spurious);
    end
    @(posedge clk); #1;
    db_out_valid = 1'b1;
    db_out_flag  = 4'h4;
    @(posedge clk); #1;
    db_out_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_spurious !== STATS) begin
      n_bad++; $display("FAIL spur_set: got err=%b expected %b", err_spurious, STATS);
    end
    for (int unsigned c = 0; c < 6; c++) begin
      if (out_valid !== '0) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (err_spurious !== STATS || pulses != 0) begin
      n_bad++; $display("FAIL spur_sticky: got err=%b out pulses=%0d expected err=%b pulses=0", err_spurious, pulses, STATS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 2'b01;
    for (int unsigned i = 0; i < 16; i++) begin
      in_key[0 +: KS] = mk_key(0, 400 + i);
      @(posedge clk); #1;
    end
    in_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 2'b10;
    in_key[KS +: KS] = mk_key(1, 500);
    repeat (108) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (drop_cnt[31:16] !== (STATS ? 16'd100 : 16'd0)) begin
      n_bad++; $display("FAIL sat_partial: got drop_cnt[1]=%0d expected %0d", drop_cnt[31:16], STATS ? 100 : 0);
    end
    repeat (70000) @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (drop_cnt !== (STATS ? 32'hFFFF_0000 : 32'h0)) begin
      n_bad++; $display("FAIL sat_full: got drop_cnt=%h expected %h", drop_cnt, STATS ? 32'hFFFF_0000 : 32'h0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_overflow();
    test_reset_mid();
    test_spurious();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
